// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_prefetch_queue
//  Purpose  : FIFO prefetch buffer between the fetch unit and the instruction
//             register. Buffers (opcode, address) words in order and presents
//             the head over a valid/ready handshake. A flush empties the queue
//             and loads a new expected address; later fetches whose address
//             does not match the expected sequential address are consumed
//             and dropped.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             in_valid/in_ready - fetch-side handshake
//             in_opcode/in_address - fetched word
//             out_valid/out_ready - IR-side handshake
//             out_opcode/out_address - head entry
//             flush/flush_addr  - redirect pulse and new expected address
//             count             - current occupancy
//             stale_drop        - pulse: a word was dropped last cycle
//  Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue #(
    parameter int unsigned          DEPTH      = 4,
    parameter int unsigned          OPCODE_W   = 16,
    parameter int unsigned          ADDR_W     = 64,
    parameter int unsigned          ADDR_STEP  = 2,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_W-1:0]      in_opcode,
    input  logic [ADDR_W-1:0]        in_address,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_W-1:0]      out_opcode,
    output logic [ADDR_W-1:0]        out_address,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        flush_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     stale_drop
);

    localparam int unsigned           c_ptr_w = $clog2(DEPTH);
    localparam int unsigned           c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]    c_full  = c_cnt_w'(DEPTH);
    localparam logic [ADDR_W-1:0]     c_step  = ADDR_W'(ADDR_STEP);

    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
    logic                stale_drop_q, stale_drop_d;

    // Storage is deliberately left unreset; out_* are don't-care while empty.
    logic [OPCODE_W-1:0] mem_opcode_q [DEPTH];
    logic [ADDR_W-1:0]   mem_addr_q   [DEPTH];

    logic w_accept;
    logic w_pop;
    logic w_match;
    logic w_store;
    logic w_drop;

    always_comb begin
        in_ready    = !rst && !flush && (count_q != c_full);
        out_valid   = !rst && !flush && (count_q != '0);
        out_opcode  = mem_opcode_q[rd_ptr_q];
        out_address = mem_addr_q[rd_ptr_q];

        w_accept = in_valid && in_ready;
        w_pop    = out_valid && out_ready;
        w_match  = (in_address == exp_addr_q);
        // A mismatching word still completes its handshake so the fetch unit
        // can drain stale in-flight requests; it simply never takes a slot.
        w_store  = w_accept && w_match;
        w_drop   = w_accept && !w_match;
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        exp_addr_d   = exp_addr_q;
        stale_drop_d = 1'b0;

        if (flush) begin
            // No accept or pop can happen in a flush cycle (handshakes are
            // gated), so the queue restarts cleanly at slot 0.
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            exp_addr_d = flush_addr;
        end else begin
            stale_drop_d = w_drop;
            if (w_store) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                exp_addr_d = exp_addr_q + c_step;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // A dropped word occupies no slot, so only store vs. pop matters.
            case ({w_store, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            exp_addr_q   <= RESET_ADDR;
            stale_drop_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            exp_addr_q   <= exp_addr_d;
            stale_drop_q <= stale_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            mem_opcode_q[wr_ptr_q] <= in_opcode;
            mem_addr_q[wr_ptr_q]   <= in_address;
        end
    end

    assign count      = count_q;
    assign stale_drop = stale_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_prefetch_queue
//  Purpose  : Self-checking bench for instr_prefetch_queue. A queue-based
//             reference model tracks contents, expected address and the
//             stale-drop pulse; directed scenarios plus a randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int OW    = 16;
    localparam int AW    = 64;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] RESET_ADDR = '0;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, flush, stale_drop;
    logic [OW-1:0] in_opcode, out_opcode;
    logic [AW-1:0] in_address, out_address, flush_addr;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    instr_prefetch_queue #(
        .DEPTH(DEPTH), .OPCODE_W(OW), .ADDR_W(AW), .ADDR_STEP(2), .RESET_ADDR(RESET_ADDR)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_address(in_address),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_address(out_address),
        .flush(flush), .flush_addr(flush_addr), .count(count), .stale_drop(stale_drop)
    );

    typedef struct packed { logic [OW-1:0] op; logic [AW-1:0] addr; } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] m_exp;
    logic          m_stale;
    int            vectors = 0;
    int            errors  = 0;

    // Reference model: advance one clock using the inputs currently applied.
    task automatic tick();
        logic rdy, vld;
        rdy = !rst && !flush && (mq.size() != DEPTH);
        vld = !rst && !flush && (mq.size() != 0);
        if (rst) begin
            mq.delete(); m_exp = RESET_ADDR; m_stale = 1'b0;
        end else if (flush) begin
            mq.delete(); m_exp = flush_addr; m_stale = 1'b0;
        end else begin
            m_stale = 1'b0;
            if (vld && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) begin
                if (in_address == m_exp) begin
                    mq.push_back({in_opcode, in_address});
                    m_exp = m_exp + 64'd2;
                end else begin
                    m_stale = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic [OW-1:0] op, input logic [AW-1:0] a,
                         input logic ordy, input logic fl, input logic [AW-1:0] fa);
        in_valid = v; in_opcode = op; in_address = a;
        out_ready = ordy; flush = fl; flush_addr = fa;
    endtask

    // Protocol properties checked every cycle.
    logic          hold_prev = 1'b0;
    logic [OW-1:0] op_prev;
    logic [AW-1:0] ad_prev;
    always @(negedge clk) begin
        if (count > CW'(DEPTH)) begin
            errors++; $display("FAIL prop_count_max: count %0d exceeds %0d", count, DEPTH);
        end
        if (in_valid && in_ready && count == CW'(DEPTH)) begin
            errors++; $display("FAIL prop_push_full: accepted with count %0d", count);
        end
        if (hold_prev && out_valid && (out_opcode !== op_prev || out_address !== ad_prev)) begin
            errors++; $display("FAIL prop_out_stable: got %h/%h want %h/%h", out_opcode, out_address, op_prev, ad_prev);
        end
        hold_prev = out_valid && !out_ready;
        op_prev   = out_opcode;
        ad_prev   = out_address;
    end

    task automatic test_reset();
        rst = 1'b1; drive(1'b1, 16'h0, 64'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tick(); tick();
        rst = 1'b0; drive(1'b0, 16'h0, 64'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        vectors++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_after: got %b want 0", out_valid); end
        vectors++; if (stale_drop !== 1'b0) begin errors++; $display("FAIL reset_stale: got %b want 0", stale_drop); end
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(i * 16'h1111), 64'(2 * i), 1'b1, 1'b0, 64'h0);
            @(negedge clk);
            vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
            vectors++; if (stale_drop !== 1'b0) begin errors++; $display("FAIL stream_stale[%0d]: got %b want 0", i, stale_drop); end
            if (i > 0) begin
                vectors++; if (out_valid !== 1'b1 || out_address !== 64'(2 * (i - 1)) || out_opcode !== 16'((i - 1) * 16'h1111)) begin
                    errors++; $display("FAIL stream_out[%0d]: got v=%b %h@%h want v=1 %h@%h", i, out_valid, out_opcode, out_address,
                                       16'((i - 1) * 16'h1111), 64'(2 * (i - 1)));
                end
                vectors++; if (count !== CW'(1)) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count); end
            end
            tick();
        end
        drive(1'b0, 16'h0, 64'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_address !== 64'h4 || out_opcode !== 16'h2222) begin
            errors++; $display("FAIL stream_last: got v=%b %h@%h want v=1 2222@4", out_valid, out_opcode, out_address);
        end
        tick();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL stream_drain: got v=%b cnt=%0d want 0/0", out_valid, count); end
        tick();
    endtask

    task automatic test_full();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'hA0 + i), 64'(2 * i), 1'b0, 1'b0, 64'h0);
            @(negedge clk);
            vectors++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL full_in_ready[%0d]: got %b want %b", i, in_ready, (i < 4)); end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (count !== CW'(4) || in_ready !== 1'b0 || out_address !== 64'h0) begin
            errors++; $display("FAIL full_pop: got cnt=%0d rdy=%b addr=%h want 4/0/0", count, in_ready, out_address);
        end
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        vectors++; if (count !== CW'(3) || in_ready !== 1'b1 || out_address !== 64'h2) begin
            errors++; $display("FAIL full_after_pop: got cnt=%0d rdy=%b addr=%h want 3/1/2", count, in_ready, out_address);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (count !== CW'(4) || stale_drop !== 1'b0) begin errors++; $display("FAIL full_refill: got cnt=%0d stale=%b want 4/0", count, stale_drop); end
    endtask

    task automatic test_flush();
        drive(1'b0, 16'h0, 64'h0, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 16'h1, 64'd10, 1'b1, 1'b1, 64'h100);
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_gate: got rdy=%b v=%b want 0/0", in_ready, out_valid); end
        tick();
        drive(1'b1, 16'h1, 64'd10, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        vectors++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty: got cnt=%0d v=%b rdy=%b want 0/0/1", count, out_valid, in_ready);
        end
        tick();
        in_address = 64'd12;
        @(negedge clk);
        vectors++; if (stale_drop !== 1'b1) begin errors++; $display("FAIL flush_drop1: got %b want 1", stale_drop); end
        tick();
        in_address = 64'h100; in_opcode = 16'hABCD;
        @(negedge clk);
        vectors++; if (stale_drop !== 1'b1 || count !== '0) begin errors++; $display("FAIL flush_drop2: got stale=%b cnt=%0d want 1/0", stale_drop, count); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (stale_drop !== 1'b0 || out_valid !== 1'b1 || out_address !== 64'h100 || out_opcode !== 16'hABCD) begin
            errors++; $display("FAIL flush_restart: got stale=%b v=%b %h@%h want 0/1 abcd@100", stale_drop, out_valid, out_opcode, out_address);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1'b1, 16'h10, 64'h0, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b1, 16'h12, 64'h2, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b1, 16'h14, 64'h4, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        vectors++; if (count !== CW'(2) || out_address !== 64'h0) begin errors++; $display("FAIL b2b_pre: got cnt=%0d addr=%h want 2/0", count, out_address); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (count !== CW'(2) || out_address !== 64'h2 || out_opcode !== 16'h12) begin
            errors++; $display("FAIL b2b_post: got cnt=%0d %h@%h want 2 0012@2", count, out_opcode, out_address);
        end
        tick();
        @(negedge clk);
        vectors++; if (out_address !== 64'h4 || out_opcode !== 16'h14) begin errors++; $display("FAIL b2b_tail: got %h@%h want 0014@4", out_opcode, out_address); end
        tick();
    endtask

    task automatic test_wrap();
        drive(1'b0, 16'h0, 64'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE); tick();
        drive(1'b1, 16'h77, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b1, 16'h78, 64'h0, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b1, 16'h79, 64'h2, 1'b0, 1'b0, 64'h0); tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (count !== CW'(3) || stale_drop !== 1'b0 || out_address !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL wrap: got cnt=%0d stale=%b addr=%h want 3/0/fffffffffffffffe", count, stale_drop, out_address);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; drive(1'b0, 16'h0, 64'h0, 1'b0, 1'b1, 64'h500);
        tick();
        rst = 1'b0; drive(1'b1, 16'h5, 64'h500, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        vectors++; if (count !== '0 || stale_drop !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid: got cnt=%0d stale=%b rdy=%b v=%b want 0/0/1/0", count, stale_drop, in_ready, out_valid);
        end
        tick();
        drive(1'b1, 16'h6, RESET_ADDR, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        vectors++; if (stale_drop !== 1'b1) begin errors++; $display("FAIL rstmid_drop: got %b want 1", stale_drop); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_address !== RESET_ADDR || count !== CW'(1)) begin
            errors++; $display("FAIL rstmid_restart: got v=%b addr=%h cnt=%0d want 1/%h/1", out_valid, out_address, count, RESET_ADDR);
        end
        tick();
    endtask

    task automatic test_random();
        logic m_rdy, m_vld;
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 99) < 2);
            flush      = ($urandom_range(0, 99) < 6);
            flush_addr = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFA : ({$urandom, $urandom} & ~64'h1);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_opcode  = 16'($urandom);
            in_address = ($urandom_range(0, 3) != 0) ? m_exp : m_exp + 64'(2 * $urandom_range(1, 6));
            out_ready  = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            m_rdy = !rst && !flush && (mq.size() != DEPTH);
            m_vld = !rst && !flush && (mq.size() != 0);
            vectors++; if (in_ready !== m_rdy) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, m_rdy); end
            vectors++; if (out_valid !== m_vld) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", n, out_valid, m_vld); end
            vectors++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, count, mq.size()); end
            vectors++; if (stale_drop !== m_stale) begin errors++; $display("FAIL rand_stale[%0d]: got %b want %b", n, stale_drop, m_stale); end
            if (m_vld) begin
                vectors++; if (out_opcode !== mq[0].op || out_address !== mq[0].addr) begin
                    errors++; $display("FAIL rand_head[%0d]: got %h@%h want %h@%h", n, out_opcode, out_address, mq[0].op, mq[0].addr);
                end
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 64'h0, 1'b0, 1'b0, 64'h0);
        mq.delete(); m_exp = RESET_ADDR; m_stale = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
